tamagotchi_needs_engine: RTL and testbench
==========================================

Name: tamagotchi_needs_engine

Overview:
Parametrised needs engine for the pet, generalising the fixed four-need FSM to NUM_NEEDS independent channels.
- Each channel has a saturating level, a runtime-programmable decay period and its own feed button.
- A test mode forces each level to either 1 or MAX_LEVEL.
- The engine sits between the debounced board buttons and the face/7-segment display logic, and exports the selected need's level, mood and per-need alarms.

Parameters:
NUM_NEEDS, 4, number of need channels (2..8)
LW, 4, level width in bits
MAX_LEVEL, 10, saturation ceiling (must be >=2 and <2**LW)
INIT_LEVEL, 8, level after hard or soft reset
STEP, 1, increment applied per feed press in normal mode
HAPPY_THRESH, 5, happy when selected level >= this value
TICK_DIV, 1875000, clk cycles per decay tick
TW, 16, decay timer width

Ports:
clk  in  1  system clock, 50 MHz
reset  in  1  asynchronous, active-low reset
btn_feed  in  NUM_NEEDS  raw feed buttons, one per need, active-high
btn_test  in  1  raw button; a rising edge toggles test mode
btn_reset  in  1  raw button; a rising edge performs a soft reset
decay_period  in  NUM_NEEDS*TW  ticks per decrement for each channel, channel i at [i*TW +: TW]; 0 disables decay
test_mode  out  1  1 while in test mode
sel_idx  out  $clog2(NUM_NEEDS)  currently selected need
sel_level  out  LW  level of the selected need
happy  out  1  sel_level >= HAPPY_THRESH
alarm  out  NUM_NEEDS  bit i = (level i == 0)
seg  out  7  active-high gfedcba code for sel_level (0-9, A-F)
tick  out  1  one-cycle decay tick strobe, for display blink logic

Behaviour:
Reset (reset=0, asynchronous):
- All levels = INIT_LEVEL; timers, prescaler and sel_idx = 0; test_mode = 0; tick = 0.
- alarm = 0; happy = (INIT_LEVEL >= HAPPY_THRESH); seg = code(INIT_LEVEL).

Input conditioning:
- All buttons pass through a 2-flop synchroniser, then a rising-edge detector.
- A press is a 1-cycle pulse arriving 3 clk after the pin rises.
- A held button generates exactly one press.

Prescaler:
- Counts 0..TICK_DIV-1; tick=1 in the cycle the counter wraps.

Per channel i in normal mode, evaluated each clk:
- dec = tick && period_i != 0 && timer_i == period_i-1. On dec, timer_i is cleared; otherwise timer_i increments on each tick.
- A period_i change takes effect at the next compare. If timer_i >= new period_i, the next tick forces dec and clears timer_i.
- inc = feed press on channel i.
- Next level = sat(level + (inc ? STEP : 0) - (dec ? 1 : 0)), clamped to 0..MAX_LEVEL. Simultaneous inc and dec apply the net value in the same cycle.

Test mode:
- Timers are held at 0 and there is no decay.
- A press on channel i sets level := (level == 1) ? MAX_LEVEL : 1.

Selection:
- Any feed press sets sel_idx to the lowest-index pressed channel.
- All pressed channels update in the same cycle.

btn_test press:
- Toggles test_mode and clears all timers.
- Levels are unchanged.

btn_reset press (soft reset):
- Behaves as hard reset except the prescaler keeps running.
- If it coincides with feed or test presses, soft reset wins and those presses are dropped.

Outputs:
- sel_level, happy, seg and alarm are registered.
- They reflect the level state one clk after that state updates.
- Every change is visible on the outputs 1 clk after the level changes.

Decomposition:
- tamagotchi_pkg holds:
  - the 16-entry SEG_LUT constant and the seg_encode function;
  - the MODE_NORMAL/MODE_TEST enum;
  - the SELW localparam helper.
- Sub-module need_channel (level register, decay timer, saturation and test toggle) is instantiated NUM_NEEDS times via generate.
- The top level contains the synchronisers, prescaler, selection priority and output registers.

Test Plan:
- Bench config: TICK_DIV=4, NUM_NEEDS=4.
- Reset release, decay_period={0,0,0,3} -> level0 goes 8→7 after 3 ticks (12 clk), reaches 0 after 24 ticks; alarm[0]=1, then stays at 0 with no underflow.
- Three feed presses on ch2 with level 8, MAX=10 -> level2 becomes 9, 10, 10; sel_idx=2, seg=7'b1110111 (A).
- Feed press on ch1 in the same cycle as its dec, level 5 -> level stays 5; happy stays 1.
- Simultaneous presses on ch3 and ch1 -> both increment; sel_idx=1.
- btn_test press, then ch0 press twice at level 8 -> test_mode=1, level0 goes 8→1→10; no decay for 100 ticks; second btn_test press returns to normal with timers at 0.
- btn_reset press while ch2=3 and in test mode -> all levels 8, test_mode=0, sel_idx=0; a held btn_reset yields one soft reset only. Async reset pulse mid-tick -> all outputs reach reset values immediately.

Source files
------------

// File: rtl/tamagotchi_needs_engine_pkg.sv
// ---------------------------------------------------------------------------
// tamagotchi_pkg
// Shared types and helpers for the pet needs engine.
//   mode_t      : engine operating mode (normal decay/feed vs. test toggling)
//   selw()      : width of a need-index field for a given channel count
//   SEG_LUT     : active-high gfedcba 7-segment patterns for 0-9, A-F
//   seg_encode(): nibble -> 7-segment pattern
// ---------------------------------------------------------------------------
package tamagotchi_pkg;

   typedef enum logic {
      MODE_NORMAL = 1'b0,
      MODE_TEST   = 1'b1
   } mode_t;

   // Index width for n channels; never narrower than one bit.
   function automatic int selw(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // Entry 15 first, entry 0 last, so SEG_LUT[v] yields the pattern for v.
   localparam logic [15:0][6:0] SEG_LUT = {
      7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
      7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
   };

   function automatic logic [6:0] seg_encode(input logic [3:0] v);
      return SEG_LUT[v];
   endfunction

endpackage

// File: rtl/tamagotchi_needs_engine_if.sv
// ---------------------------------------------------------------------------
// tamagotchi_needs_engine_if
// Bundles the board-facing signals of the needs engine.
//   btn_feed/btn_test/btn_reset : raw push buttons (driven by master)
//   decay_period                : per-channel ticks per decrement (master)
//   test_mode, sel_idx, sel_level, happy, alarm, seg, tick : engine status
// modport master : board / display side
// modport slave  : the engine itself
// ---------------------------------------------------------------------------
interface tamagotchi_needs_engine_if
   import tamagotchi_pkg::*;
#(
   parameter int NUM_NEEDS = 4,
   parameter int LW        = 4,
   parameter int TW        = 16
) ();

   logic [NUM_NEEDS-1:0]         btn_feed;
   logic                         btn_test;
   logic                         btn_reset;
   logic [NUM_NEEDS*TW-1:0]      decay_period;

   logic                         test_mode;
   logic [selw(NUM_NEEDS)-1:0]   sel_idx;
   logic [LW-1:0]                sel_level;
   logic                         happy;
   logic [NUM_NEEDS-1:0]         alarm;
   logic [6:0]                   seg;
   logic                         tick;

   modport master (
      output btn_feed, btn_test, btn_reset, decay_period,
      input  test_mode, sel_idx, sel_level, happy, alarm, seg, tick
   );

   modport slave (
      input  btn_feed, btn_test, btn_reset, decay_period,
      output test_mode, sel_idx, sel_level, happy, alarm, seg, tick
   );

endinterface

// File: rtl/tamagotchi_needs_engine_need_channel.sv
// ---------------------------------------------------------------------------
// need_channel
// One need: saturating level register plus its decay timer.
//   clk, reset     : clock, asynchronous active-low reset
//   soft_rst       : 1-cycle pulse, restores INIT_LEVEL and clears the timer
//   clr_timer      : 1-cycle pulse on a mode toggle, clears the timer only
//   mode           : normal (feed/decay) or test (toggle 1 <-> MAX_LEVEL)
//   tick           : prescaler strobe
//   period         : ticks per decrement, 0 disables decay
//   press          : 1-cycle feed pulse for this channel
//   level          : current level
// ---------------------------------------------------------------------------
module need_channel
   import tamagotchi_pkg::*;
#(
   parameter int LW         = 4,
   parameter int MAX_LEVEL  = 10,
   parameter int INIT_LEVEL = 8,
   parameter int STEP       = 1,
   parameter int TW         = 16
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          soft_rst,
   input  logic          clr_timer,
   input  mode_t         mode,
   input  logic          tick,
   input  logic [TW-1:0] period,
   input  logic          press,
   output logic [LW-1:0] level
);

   logic [LW-1:0] level_reg, level_next;
   logic [TW-1:0] timer_reg, timer_next;
   logic          dec;
   int            sum;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         level_reg <= LW'(INIT_LEVEL);
         timer_reg <= '0;
      end else begin
         level_reg <= level_next;
         timer_reg <= timer_next;
      end
   end

   always_comb begin
      dec        = 1'b0;
      sum        = 0;
      level_next = level_reg;
      timer_next = timer_reg;

      if (mode == MODE_TEST) begin
         timer_next = '0;
         if (press)
            level_next = (level_reg == LW'(1)) ? LW'(MAX_LEVEL) : LW'(1);
      end else begin
         // ">=" rather than "==" so that shrinking the period below the
         // running timer still fires on the very next tick.
         dec = tick && (period != '0) && (timer_reg >= period - TW'(1));
         if (dec)
            timer_next = '0;
         else if (tick)
            timer_next = timer_reg + TW'(1);

         // Signed arithmetic so a simultaneous feed and decay nets out
         // before clamping.
         sum = int'(level_reg) + (press ? STEP : 0) - (dec ? 1 : 0);
         if (sum < 0)
            level_next = '0;
         else if (sum > MAX_LEVEL)
            level_next = LW'(MAX_LEVEL);
         else
            level_next = LW'(sum);
      end

      if (clr_timer)
         timer_next = '0;

      // Soft reset overrides any feed arriving in the same cycle.
      if (soft_rst) begin
         level_next = LW'(INIT_LEVEL);
         timer_next = '0;
      end
   end

   assign level = level_reg;

endmodule

// File: rtl/tamagotchi_needs_engine.sv
// ---------------------------------------------------------------------------
// tamagotchi_needs_engine
// NUM_NEEDS independent need channels with shared decay prescaler, button
// conditioning, need selection and registered display outputs.
//   clk   : system clock
//   reset : asynchronous active-low reset
//   bus   : slave side of tamagotchi_needs_engine_if (buttons, decay
//           periods in; test_mode, sel_idx, sel_level, happy, alarm, seg,
//           tick out)
// ---------------------------------------------------------------------------
module tamagotchi_needs_engine
   import tamagotchi_pkg::*;
#(
   parameter int NUM_NEEDS    = 4,
   parameter int LW           = 4,
   parameter int MAX_LEVEL    = 10,
   parameter int INIT_LEVEL   = 8,
   parameter int STEP         = 1,
   parameter int HAPPY_THRESH = 5,
   parameter int TICK_DIV     = 1875000,
   parameter int TW           = 16
) (
   input logic                      clk,
   input logic                      reset,
   tamagotchi_needs_engine_if.slave bus
);

   localparam int NB = NUM_NEEDS + 2;
   localparam int SW = selw(NUM_NEEDS);
   localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

   // ---------------- button conditioning ----------------
   // Bit order: feed buttons, then test, then reset.
   logic [NB-1:0] btn_raw;
   logic [NB-1:0] sync1_reg, sync2_reg, sync3_reg, press_reg;

   assign btn_raw = {bus.btn_reset, bus.btn_test, bus.btn_feed};

   generate
      for (genvar gi = 0; gi < NB; gi++) begin : g_btn
         always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
               sync1_reg[gi] <= 1'b0;
               sync2_reg[gi] <= 1'b0;
               sync3_reg[gi] <= 1'b0;
               press_reg[gi] <= 1'b0;
            end else begin
               sync1_reg[gi] <= btn_raw[gi];
               sync2_reg[gi] <= sync1_reg[gi];
               sync3_reg[gi] <= sync2_reg[gi];
               press_reg[gi] <= sync2_reg[gi] & ~sync3_reg[gi];
            end
         end
      end
   endgenerate

   logic [NUM_NEEDS-1:0] press_feed;
   logic                 press_test, press_rst;

   assign press_feed = press_reg[NUM_NEEDS-1:0];
   assign press_test = press_reg[NUM_NEEDS];
   assign press_rst  = press_reg[NUM_NEEDS+1];

   // ---------------- decay prescaler ----------------
   // Not touched by soft reset so the tick cadence never slips.
   logic [PW-1:0] presc_reg;
   logic          tick;

   assign tick = (presc_reg == PW'(TICK_DIV - 1));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         presc_reg <= '0;
      else if (tick)
         presc_reg <= '0;
      else
         presc_reg <= presc_reg + PW'(1);
   end

   // ---------------- mode FSM ----------------
   mode_t mode_reg, mode_next;
   logic  in_test;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         mode_reg <= MODE_NORMAL;
      else
         mode_reg <= mode_next;
   end

   always_comb begin
      mode_next = mode_reg;
      if (press_rst)
         mode_next = MODE_NORMAL;
      else if (press_test)
         mode_next = (mode_reg == MODE_TEST) ? MODE_NORMAL : MODE_TEST;
   end

   always_comb begin
      in_test = (mode_reg == MODE_TEST);
   end

   // ---------------- selection ----------------
   logic [SW-1:0] sel_reg, sel_next;

   always_comb begin
      sel_next = sel_reg;
      // Scan downwards so the lowest pressed index is the one that sticks.
      for (int i = NUM_NEEDS - 1; i >= 0; i--) begin
         if (press_feed[i])
            sel_next = SW'(i);
      end
      if (press_rst)
         sel_next = '0;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         sel_reg <= '0;
      else
         sel_reg <= sel_next;
   end

   // ---------------- channels ----------------
   logic [LW-1:0]        level_arr [NUM_NEEDS];
   logic [NUM_NEEDS-1:0] alarm_next;

   generate
      for (genvar gi = 0; gi < NUM_NEEDS; gi++) begin : g_ch
         need_channel #(
            .LW         (LW),
            .MAX_LEVEL  (MAX_LEVEL),
            .INIT_LEVEL (INIT_LEVEL),
            .STEP       (STEP),
            .TW         (TW)
         ) u_ch (
            .clk       (clk),
            .reset     (reset),
            .soft_rst  (press_rst),
            .clr_timer (press_test),
            .mode      (mode_reg),
            .tick      (tick),
            .period    (bus.decay_period[gi*TW +: TW]),
            .press     (press_feed[gi]),
            .level     (level_arr[gi])
         );
         assign alarm_next[gi] = (level_arr[gi] == '0);
      end
   endgenerate

   // ---------------- registered display outputs ----------------
   // Index and mode are delayed with the level so the display never shows
   // a new index paired with the previous channel's level.
   logic [LW-1:0]        sel_level_cur;
   logic                 test_mode_reg;
   logic [SW-1:0]        sel_out_reg;
   logic [LW-1:0]        sel_level_reg;
   logic                 happy_reg;
   logic [NUM_NEEDS-1:0] alarm_reg;
   logic [6:0]           seg_reg;

   assign sel_level_cur = level_arr[sel_reg];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         test_mode_reg <= 1'b0;
         sel_out_reg   <= '0;
         sel_level_reg <= LW'(INIT_LEVEL);
         happy_reg     <= (INIT_LEVEL >= HAPPY_THRESH);
         alarm_reg     <= '0;
         seg_reg       <= seg_encode(4'(INIT_LEVEL));
      end else begin
         test_mode_reg <= in_test;
         sel_out_reg   <= sel_reg;
         sel_level_reg <= sel_level_cur;
         happy_reg     <= (sel_level_cur >= LW'(HAPPY_THRESH));
         alarm_reg     <= alarm_next;
         seg_reg       <= seg_encode(4'(sel_level_cur));
      end
   end

   assign bus.test_mode = test_mode_reg;
   assign bus.sel_idx   = sel_out_reg;
   assign bus.sel_level = sel_level_reg;
   assign bus.happy     = happy_reg;
   assign bus.alarm     = alarm_reg;
   assign bus.seg       = seg_reg;
   assign bus.tick      = tick;

endmodule

// File: tb/tb_tamagotchi_needs_engine.sv
// ---------------------------------------------------------------------------
// tb_tamagotchi_needs_engine
// Directed stimulus with a scoreboard: each expected change of the display
// outputs is queued by the stimulus; a monitor pops one entry whenever the
// registered outputs change and compares them (and, where given, the cycle).
// ---------------------------------------------------------------------------
module tb_tamagotchi_needs_engine;

   logic clk   = 1'b0;
   logic reset = 1'b0;

   always #5 clk = ~clk;

   tamagotchi_needs_engine_if #(.NUM_NEEDS(4), .LW(4), .TW(16)) bus ();

   tamagotchi_needs_engine #(
      .NUM_NEEDS(4), .LW(4), .MAX_LEVEL(10), .INIT_LEVEL(8), .STEP(1),
      .HAPPY_THRESH(5), .TICK_DIV(4), .TW(16)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   typedef struct {
      string      name;
      logic       tm;
      logic [1:0] sel;
      logic [3:0] lvl;
      logic       hap;
      logic [3:0] alm;
      logic [6:0] sg;
      int         cyc;
   } exp_t;

   exp_t q[$];
   int   total = 0;
   int   bad   = 0;
   int   cyc   = 0;
   int   c0    = 0;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [6:0] seg_of(input int v);
      case (v)
         0: return 7'h3F;  1: return 7'h06;  2: return 7'h5B;  3: return 7'h4F;
         4: return 7'h66;  5: return 7'h6D;  6: return 7'h7D;  7: return 7'h07;
         8: return 7'h7F;  9: return 7'h6F; 10: return 7'h77; 11: return 7'h7C;
        12: return 7'h39; 13: return 7'h5E; 14: return 7'h79; default: return 7'h71;
      endcase
   endfunction

   function automatic void push(input string nm, input logic tm, input int sel,
                                input int lvl, input logic [3:0] alm, input int cw);
      exp_t e;
      e.name = nm; e.tm = tm; e.sel = 2'(sel); e.lvl = 4'(lvl);
      e.hap = (lvl >= 5); e.alm = alm; e.sg = seg_of(lvl); e.cyc = cw;
      q.push_back(e);
   endfunction

   task automatic chk(input string nm, input int got, input int want);
      total++;
      if (got != want) begin
         bad++;
         $display("FAIL %s: got=%0d want=%0d", nm, got, want);
      end
   endtask

   // ---------------- monitor ----------------
   initial begin
      logic [18:0] prev, cur;
      exp_t        e;
      prev = '0;
      forever begin
         @(negedge clk);
         cur = {bus.test_mode, bus.sel_idx, bus.sel_level, bus.happy, bus.alarm, bus.seg};
         if (!reset) begin
            prev = cur;
         end else if (cur != prev) begin
            prev = cur;
            total++;
            if (q.size() == 0) begin
               bad++;
               $display("FAIL unexpected_change: got tm=%0b sel=%0d lvl=%0d hap=%0b alm=%b seg=%h at cyc=%0d, none expected",
                        bus.test_mode, bus.sel_idx, bus.sel_level, bus.happy, bus.alarm, bus.seg, cyc - c0);
            end else begin
               e = q.pop_front();
               if (bus.test_mode !== e.tm || bus.sel_idx !== e.sel || bus.sel_level !== e.lvl ||
                   bus.happy !== e.hap || bus.alarm !== e.alm || bus.seg !== e.sg ||
                   (e.cyc >= 0 && cyc != e.cyc)) begin
                  bad++;
                  $display("FAIL %s: got tm=%0b sel=%0d lvl=%0d hap=%0b alm=%b seg=%h cyc=%0d, want tm=%0b sel=%0d lvl=%0d hap=%0b alm=%b seg=%h cyc=%0d",
                           e.name, bus.test_mode, bus.sel_idx, bus.sel_level, bus.happy, bus.alarm, bus.seg, cyc,
                           e.tm, e.sel, e.lvl, e.hap, e.alm, e.sg, e.cyc);
               end else begin
                  $display("ok   %s: tm=%0b sel=%0d lvl=%0d alm=%b seg=%h cyc=%0d",
                           e.name, bus.test_mode, bus.sel_idx, bus.sel_level, bus.alarm, bus.seg, cyc - c0);
               end
            end
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic wait_until(input int target);
      while (cyc < target) @(negedge clk);
   endtask

   task automatic align_tick(output int t);
      do @(negedge clk); while (((cyc - c0) % 4) != 0);
      t = cyc;
   endtask

   task automatic press_btn(input logic [3:0] feed, input logic t, input logic r);
      bus.btn_feed = feed; bus.btn_test = t; bus.btn_reset = r;
      repeat (5) @(negedge clk);
      bus.btn_feed = '0; bus.btn_test = 1'b0; bus.btn_reset = 1'b0;
      repeat (6) @(negedge clk);
   endtask

   // Wait for all queued events, report any that never came, then idle so
   // stray output changes are caught by the monitor.
   task automatic drain(input string nm, input int idle);
      exp_t e;
      for (int i = 0; i < 200 && q.size() != 0; i++) @(negedge clk);
      while (q.size() != 0) begin
         e = q.pop_front();
         total++; bad++;
         $display("FAIL %s_missing: got no output change, want %s (lvl=%0d sel=%0d)", nm, e.name, e.lvl, e.sel);
      end
      repeat (idle) @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no completion, want finish before time limit");
      $fatal(1, "watchdog expired");
   end

   // ---------------- stimulus ----------------
   initial begin
      int tm;
      bus.btn_feed = '0; bus.btn_test = 1'b0; bus.btn_reset = 1'b0;
      bus.decay_period = {16'd0, 16'd0, 16'd0, 16'd3};

      repeat (3) @(negedge clk);
      chk("rst_test_mode", int'(bus.test_mode), 0);
      chk("rst_sel_idx",   int'(bus.sel_idx),   0);
      chk("rst_sel_level", int'(bus.sel_level), 8);
      chk("rst_happy",     int'(bus.happy),     1);
      chk("rst_alarm",     int'(bus.alarm),     0);
      chk("rst_seg",       int'(bus.seg),       'h7F);
      chk("rst_tick",      int'(bus.tick),      0);

      // Decay on ch0, period 3: one step every 12 clk, visible 1 clk later.
      reset = 1'b1;
      c0 = cyc;
      for (int k = 1; k <= 8; k++)
         push($sformatf("decay0_to_%0d", 8 - k), 1'b0, 0, 8 - k,
              (k == 8) ? 4'b0001 : 4'b0000, c0 + 12 * k + 1);
      for (int j = 0; j < 8; j++) begin
         @(negedge clk);
         chk("tick_phase", int'(bus.tick), (((cyc - c0) % 4) == 3) ? 1 : 0);
      end
      wait_until(c0 + 97);
      drain("decay0", 24);
      chk("no_underflow", int'(bus.sel_level), 0);

      // Three feeds on ch2: 9, 10, then saturation (no visible change).
      bus.decay_period = '0;
      push("feed2_9",  1'b0, 2, 9,  4'b0001, -1);
      push("feed2_10", 1'b0, 2, 10, 4'b0001, -1);
      for (int k = 0; k < 3; k++) press_btn(4'b0100, 1'b0, 1'b0);
      drain("feed2", 8);
      chk("sat_seg_A", int'(bus.seg), 'h77);

      // ch1: feed to 9, decay every tick to 5, then feed on the decay edge.
      push("feed1_9", 1'b0, 1, 9, 4'b0001, -1);
      press_btn(4'b0010, 1'b0, 1'b0);
      drain("feed1", 2);
      align_tick(tm);
      bus.decay_period = {16'd0, 16'd0, 16'd1, 16'd0};
      for (int k = 1; k <= 4; k++)
         push($sformatf("decay1_to_%0d", 9 - k), 1'b0, 1, 9 - k, 4'b0001, tm + 4 * k + 1);
      wait_until(tm + 16);
      bus.btn_feed = 4'b0010;
      wait_until(tm + 20);
      bus.decay_period = '0;
      wait_until(tm + 22);
      bus.btn_feed = '0;
      drain("feed_vs_decay", 12);
      chk("net_zero_level", int'(bus.sel_level), 5);
      chk("net_zero_happy", int'(bus.happy), 1);

      // Simultaneous feeds on ch1 and ch3, then ch3 alone.
      push("dual_feed_sel1", 1'b0, 1, 6, 4'b0001, -1);
      press_btn(4'b1010, 1'b0, 1'b0);
      drain("dual_feed", 2);
      push("feed3_10", 1'b0, 3, 10, 4'b0001, -1);
      press_btn(4'b1000, 1'b0, 1'b0);
      drain("feed3", 2);

      // Soft reset from normal mode.
      push("soft_rst_a", 1'b0, 0, 8, 4'b0000, -1);
      press_btn(4'b0000, 1'b0, 1'b1);
      drain("soft_rst_a", 4);

      // Test mode: ch0 8 -> 1 -> 10, no decay even with period 1.
      push("test_on", 1'b1, 0, 8, 4'b0000, -1);
      press_btn(4'b0000, 1'b1, 1'b0);
      drain("test_on", 2);
      push("test_ch0_1",  1'b1, 0, 1,  4'b0000, -1);
      push("test_ch0_10", 1'b1, 0, 10, 4'b0000, -1);
      press_btn(4'b0001, 1'b0, 1'b0);
      press_btn(4'b0001, 1'b0, 1'b0);
      drain("test_toggle", 2);
      bus.decay_period = {16'd1, 16'd1, 16'd1, 16'd1};
      repeat (400) @(negedge clk);
      chk("test_no_decay", int'(bus.sel_level), 10);

      // Leave test mode on a tick-aligned press: timers restart from 0.
      bus.decay_period = {16'd0, 16'd0, 16'd0, 16'd3};
      align_tick(tm);
      push("test_off",  1'b0, 0, 10, 4'b0000, tm + 5);
      push("first_dec", 1'b0, 0, 9,  4'b0000, tm + 17);
      bus.btn_test = 1'b1;
      wait_until(tm + 6);
      bus.btn_test = 1'b0;
      wait_until(tm + 18);
      bus.decay_period = '0;
      drain("test_off", 4);

      // ch2 down to 3, enter test mode, then held soft reset.
      push("feed2_again", 1'b0, 2, 9, 4'b0000, -1);
      press_btn(4'b0100, 1'b0, 1'b0);
      drain("feed2_again", 2);
      align_tick(tm);
      bus.decay_period = {16'd0, 16'd1, 16'd0, 16'd0};
      for (int k = 1; k <= 6; k++)
         push($sformatf("decay2_to_%0d", 9 - k), 1'b0, 2, 9 - k, 4'b0000, tm + 4 * k + 1);
      wait_until(tm + 24);
      bus.decay_period = '0;
      drain("decay2", 4);
      push("test_on_b", 1'b1, 2, 3, 4'b0000, -1);
      press_btn(4'b0000, 1'b1, 1'b0);
      drain("test_on_b", 2);
      tm = cyc;
      push("soft_rst_b",    1'b0, 0, 8, 4'b0000, tm + 5);
      push("feed1_in_hold", 1'b0, 1, 9, 4'b0000, tm + 10);
      bus.btn_reset = 1'b1;
      wait_until(tm + 5);
      bus.btn_feed = 4'b0010;
      wait_until(tm + 10);
      bus.btn_feed = '0;
      wait_until(tm + 14);
      bus.btn_reset = 1'b0;
      drain("soft_rst_b", 12);

      // Asynchronous reset in the middle of a clock period.
      @(posedge clk);
      #3;
      reset = 1'b0;
      #1;
      chk("arst_test_mode", int'(bus.test_mode), 0);
      chk("arst_sel_idx",   int'(bus.sel_idx),   0);
      chk("arst_sel_level", int'(bus.sel_level), 8);
      chk("arst_happy",     int'(bus.happy),     1);
      chk("arst_alarm",     int'(bus.alarm),     0);
      chk("arst_seg",       int'(bus.seg),       'h7F);
      chk("arst_tick",      int'(bus.tick),      0);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
      drain("post_reset", 10);
      chk("post_reset_level", int'(bus.sel_level), 8);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
